// File: rtl/rhythm_pkg.sv
// rhythm_pkg: shared state encodings, default timing constants and counter sizing helper.
package rhythm_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ON   = 2'd1,
        S_GAP  = 2'd2
    } state_t;

    localparam int ON_MAX_DEF    = 5_000_000;
    localparam int GAP_MAX_DEF   = 2_500_000;
    localparam int QUEUE_MAX_DEF = 7;

    // Width of a counter that must reach max(a, b) - 1; never narrower than 1 bit.
    function automatic int cnt_width(input int a, input int b);
        int m;
        m = (a > b) ? a : b;
        return (m > 1) ? $clog2(m) : 1;
    endfunction

endpackage

// File: rtl/pulse_stretch.sv
// pulse_stretch: stretches 1-clock events into ON_MAX-long high windows separated by GAP_MAX-long
// low gaps, queueing up to QUEUE_MAX events that arrive while a window or gap is in progress.
module pulse_stretch
    import rhythm_pkg::*;
#(
    parameter int ON_MAX    = ON_MAX_DEF,
    parameter int GAP_MAX   = GAP_MAX_DEF,
    parameter int QUEUE_MAX = QUEUE_MAX_DEF
) (
    input  logic       i_Clk,
    input  logic       i_Rst,
    input  logic       i_fPulse,
    output logic       o_Out,
    output logic       o_Busy,
    output logic [2:0] o_Pending,
    output logic       o_Drop
);

    localparam int CW = cnt_width(ON_MAX, GAP_MAX);

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    pend_q, pend_d;
    logic          drop_q, drop_d;
    logic          on_end, gap_end, final_gap, legal;

    assign on_end    = cnt_q == CW'(ON_MAX - 1);
    assign gap_end   = cnt_q == CW'(GAP_MAX - 1);
    assign final_gap = (state_q == S_GAP) && gap_end;
    assign legal     = state_q inside {S_IDLE, S_ON, S_GAP};

    always_comb begin
        state_d = S_IDLE;
        cnt_d   = '0;
        case (state_q)
            S_IDLE: state_d = i_fPulse ? S_ON : S_IDLE;
            S_ON: begin
                state_d = on_end ? S_GAP : S_ON;
                cnt_d   = on_end ? '0 : cnt_q + CW'(1);
            end
            S_GAP: begin
                state_d = !gap_end ? S_GAP : ((pend_q != 3'd0 || i_fPulse) ? S_ON : S_IDLE);
                cnt_d   = gap_end ? '0 : cnt_q + CW'(1);
            end
            default: ;
        endcase
    end

    always_ff @(posedge i_Clk or posedge i_Rst) begin
        if (i_Rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // A pulse in the last gap cycle either starts the next window directly (empty queue)
    // or replaces the queued event being consumed, so the count does not move.
    always_comb begin
        pend_d = pend_q;
        drop_d = 1'b0;
        if (!legal)
            pend_d = '0;
        else if (final_gap)
            pend_d = (pend_q != 3'd0 && !i_fPulse) ? pend_q - 3'd1 : pend_q;
        else if (state_q != S_IDLE && i_fPulse) begin
            if (pend_q < 3'(QUEUE_MAX))
                pend_d = pend_q + 3'd1;
            else
                drop_d = 1'b1;
        end
    end

    always_ff @(posedge i_Clk or posedge i_Rst) begin
        if (i_Rst) begin
            pend_q <= '0;
            drop_q <= 1'b0;
        end else begin
            pend_q <= pend_d;
            drop_q <= drop_d;
        end
    end

    assign o_Out     = state_q == S_ON;
    assign o_Busy    = state_q != S_IDLE;
    assign o_Pending = pend_q;
    assign o_Drop    = drop_q;

endmodule

// File: tb/tb_pulse_stretch.sv
// tb_pulse_stretch: directed scenarios and random traffic checked against a window-schedule model.
module tb_pulse_stretch;

    localparam int ON  = 4;
    localparam int GAP = 2;
    localparam int QM  = 2;

    logic       i_Clk = 1'b0;
    logic       i_Rst = 1'b1;
    logic       i_fPulse = 1'b0;
    logic       o_Out, o_Busy, o_Drop;
    logic [2:0] o_Pending;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int starts[$];
    int drop_at = -1;
    int rises, drops;
    logic prev_out;

    pulse_stretch #(.ON_MAX(ON), .GAP_MAX(GAP), .QUEUE_MAX(QM)) dut (
        .i_Clk(i_Clk), .i_Rst(i_Rst), .i_fPulse(i_fPulse),
        .o_Out(o_Out), .o_Busy(o_Busy), .o_Pending(o_Pending), .o_Drop(o_Drop)
    );

    always #5 i_Clk = ~i_Clk;

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s cycle=%0d got=%0d expected=%0d", tag, cyc, got, exp);
        end
    endtask

    // Model: each accepted event owns a window starting at a known cycle; everything else follows.
    function automatic int m_in(input int c, input int len);
        foreach (starts[k]) if (starts[k] <= c && c < starts[k] + len) return 1;
        return 0;
    endfunction

    function automatic int m_after(input int c);
        int n = 0;
        foreach (starts[k]) if (starts[k] > c) n++;
        return n;
    endfunction

    function automatic void m_pulse(input int c);
        if (m_in(c, ON + GAP) == 0) starts.push_back(c + 1);
        else if (m_after(c + 1) < QM) starts.push_back(starts[$] + ON + GAP);
        else drop_at = c + 1;
    endfunction

    task automatic step(input logic p, input logic r);
        i_Rst = r;
        i_fPulse = p;
        if (r) begin
            starts.delete();
            drop_at = -1;
        end
        @(negedge i_Clk);
        check("out", int'(o_Out), m_in(cyc, ON));
        check("busy", int'(o_Busy), m_in(cyc, ON + GAP));
        check("pending", int'(o_Pending), m_after(cyc));
        check("drop", int'(o_Drop), int'(cyc == drop_at));
        if (o_Out && !prev_out) rises++;
        if (o_Drop) drops++;
        prev_out = o_Out;
        if (p && !r) m_pulse(cyc);
        @(posedge i_Clk);
        #1;
        cyc++;
    endtask

    task automatic run_scn(input int n, input logic [63:0] pmask);
        for (int i = 0; i < 3; i++) step(1'b1, 1'b1);
        rises = 0;
        drops = 0;
        prev_out = 1'b0;
        for (int i = 0; i < n; i++) step(pmask[i], 1'b0);
    endtask

    initial begin
        int dens;
        @(posedge i_Clk);
        #1;
        cyc = 1;
        run_scn(24, 64'h400);
        check("single_windows", rises, 1);
        run_scn(34, 64'h1C00);
        check("burst_windows", rises, 3);
        check("burst_drops", drops, 0);
        run_scn(34, 64'h3C00);
        check("sat_windows", rises, 3);
        check("sat_drops", drops, 1);
        run_scn(28, 64'h10400);
        check("gapend_windows", rises, 2);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1);
        for (int i = 0; i < 30; i++)
            step(i == 10 || i == 11 || i == 20 || i == 13, i >= 12 && i < 15);
        dens = 3;
        for (int i = 0; i < 4000; i++) begin
            if (i % 100 == 0) dens = $urandom_range(0, 9);
            step($urandom_range(0, dens) == 0, $urandom_range(0, 249) == 0);
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
